// File: rtl/sop_eval_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sop_eval_pipe                                                  |
// | Brief   : 2-stage valid/ready sum-of-products evaluator, popcount, hits  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sop_eval_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic [WIDTH-1:0]             c,
  input  logic [WIDTH-1:0]             d,
  input  logic [WIDTH-1:0]             e,
  input  logic [WIDTH-1:0]             f,
  input  logic [1:0]                   mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             w,
  output logic [$clog2(WIDTH+1)-1:0]   w_ones,
  input  logic                         clr_count,
  output logic [CNT_W-1:0]             hit_count
);

  localparam int         OW         = $clog2(WIDTH+1);
  localparam logic [1:0] c_MODE_OR  = 2'b00;
  localparam logic [1:0] c_MODE_AND = 2'b01;
  localparam logic [1:0] c_MODE_XOR = 2'b10;

  logic [WIDTH-1:0] r_t0, r_t1, r_t2;
  logic [1:0]       r_mode;
  logic             r_s1_valid;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_w;
  logic [OW-1:0]    r_ones;
  logic [CNT_W-1:0] r_hit;

  logic             w_s1_load;
  logic             w_s2_load;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_comb;
  logic [OW-1:0]    w_pop;

  // in_ready depends on out_ready only, never on in_valid.
  assign w_s2_load  = r_s1_valid & (~r_out_valid | out_ready);
  assign in_ready   = ~r_s1_valid | w_s2_load;
  assign w_s1_load  = in_valid & in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  always_comb begin
    w_comb = '0;
    case (r_mode)
      c_MODE_OR:  w_comb = r_t0 | r_t1 | r_t2;
      c_MODE_AND: w_comb = r_t0 & r_t1 & r_t2;
      c_MODE_XOR: w_comb = r_t0 ^ r_t1 ^ r_t2;
      default:    w_comb = (r_t0 & r_t1) | (r_t0 & r_t2) | (r_t1 & r_t2);
    endcase
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + OW'(w_comb[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t0       <= '0;
      r_t1       <= '0;
      r_t2       <= '0;
      r_mode     <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_t0   <= a & b;
        r_t1   <= ~c & d;
        r_t2   <= e ^ f;
        r_mode <= mode;
      end
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // A load in the same edge as an output transfer replaces the result with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_w         <= '0;
      r_ones      <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_w         <= w_comb;
      r_ones      <= w_pop;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit <= '0;
    end else if (clr_count) begin
      r_hit <= '0;
    end else if (w_out_xfer && (|r_w) && !(&r_hit)) begin
      r_hit <= r_hit + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign w         = r_w;
  assign w_ones    = r_ones;
  assign hit_count = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_sop_eval_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sop_eval_pipe                                               |
// | Brief   : scoreboard bench, 8-bit/16-bit and 1-bit/4-bit instances       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sop_eval_pipe;

  typedef struct {
    logic [7:0] w;
    int         ones;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid [2];
  logic       out_ready[2];
  logic       clr      [2];
  logic [7:0] a[2], b[2], c[2], d[2], e[2], f[2];
  logic [1:0] mode[2];

  logic       ir0, ir1, ov0, ov1;
  logic [7:0] w0;
  logic [0:0] w1;
  logic [3:0] ones0;
  logic [0:0] ones1;
  logic [15:0] hit0;
  logic [3:0]  hit1;

  exp_t q0[$], q1[$];
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  int   mhit[2];
  bit   chk_lat[2], rnd_rdy[2], prev_stall[2];
  logic [7:0] prev_w[2];
  int   prev_ones[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sop_eval_pipe #(.WIDTH(8), .CNT_W(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir0),
    .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .e(e[0]), .f(f[0]), .mode(mode[0]),
    .out_valid(ov0), .out_ready(out_ready[0]), .w(w0), .w_ones(ones0),
    .clr_count(clr[0]), .hit_count(hit0)
  );

  sop_eval_pipe #(.WIDTH(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir1),
    .a(a[1][0:0]), .b(b[1][0:0]), .c(c[1][0:0]), .d(d[1][0:0]), .e(e[1][0:0]),
    .f(f[1][0:0]), .mode(mode[1]),
    .out_valid(ov1), .out_ready(out_ready[1]), .w(w1), .w_ones(ones1),
    .clr_count(clr[1]), .hit_count(hit1)
  );

  function automatic logic        get_ir(int k);   return (k == 0) ? ir0 : ir1; endfunction
  function automatic logic        get_ov(int k);   return (k == 0) ? ov0 : ov1; endfunction
  function automatic logic [7:0]  get_w(int k);    return (k == 0) ? w0 : {7'b0, w1}; endfunction
  function automatic int          get_ones(int k); return (k == 0) ? int'(ones0) : int'(ones1); endfunction
  function automatic int          get_hit(int k);  return (k == 0) ? int'(hit0) : int'(hit1); endfunction
  function automatic int          qsize(int k);    return (k == 0) ? q0.size() : q1.size(); endfunction
  function automatic int          hmax(int k);     return (k == 0) ? 65535 : 15; endfunction

  // Reference: per bit, count how many of the three terms are set and apply the mode rule.
  function automatic logic [7:0] ref_w(logic [7:0] va, vb, vc, vd, ve, vf,
                                       logic [1:0] vm, int wd);
    logic [7:0] r = '0;
    for (int i = 0; i < wd; i++) begin
      int n = int'(va[i] & vb[i]) + int'(!vc[i] & vd[i]) + int'(ve[i] ^ vf[i]);
      case (vm)
        2'd0: r[i] = (n >= 1);
        2'd1: r[i] = (n == 3);
        2'd2: r[i] = (n % 2 == 1);
        default: r[i] = (n >= 2);
      endcase
    end
    return r;
  endfunction

  function automatic int popc(logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++)
        if (rnd_rdy[k]) out_ready[k] = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Offer one transaction for up to maxc cycles; leaves in_valid high.
  task automatic send(input int k, input logic [7:0] va, vb, vc, vd, ve, vf,
                      input logic [1:0] vm, input int maxc, output bit ok);
    exp_t x;
    a[k] = va; b[k] = vb; c[k] = vc; d[k] = vd; e[k] = ve; f[k] = vf; mode[k] = vm;
    in_valid[k] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < maxc && !ok; n++) begin
      @(negedge clk);
      if (get_ir(k)) begin
        x.w    = ref_w(va, vb, vc, vd, ve, vf, vm, (k == 0) ? 8 : 1);
        x.ones = popc(x.w);
        x.cyc  = cyc;
        if (k == 0) q0.push_back(x); else q1.push_back(x);
        ok = 1'b1;
      end
      step(1);
    end
  endtask

  task automatic send_req(input int k, input logic [7:0] va, vb, vc, vd, ve, vf,
                          input logic [1:0] vm);
    bit ok;
    send(k, va, vb, vc, vd, ve, vf, vm, 50, ok);
    chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drain(input int k);
    in_valid[k] = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (qsize(k) == 0 && !get_ov(k)) break;
      step(1);
    end
    chk("drain_left", 32'(qsize(k)), 32'd0);
  endtask

  task automatic mon(input int k);
    exp_t x;
    bit   inc = 1'b0;
    chk("hit_count", 32'(get_hit(k)), 32'(mhit[k]));
    if (prev_stall[k]) begin
      chk("hold_valid", 32'(get_ov(k)), 32'd1);
      chk("hold_w", 32'(get_w(k)), 32'(prev_w[k]));
      chk("hold_ones", 32'(get_ones(k)), 32'(prev_ones[k]));
    end
    prev_stall[k] = get_ov(k) & ~out_ready[k];
    prev_w[k]     = get_w(k);
    prev_ones[k]  = get_ones(k);
    if (get_ov(k) && out_ready[k]) begin
      if (qsize(k) == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out: inst %0d produced w=%0h with nothing pending", k, get_w(k));
      end else begin
        x = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk("w", 32'(get_w(k)), 32'(x.w));
        chk("w_ones", 32'(get_ones(k)), 32'(x.ones));
        if (chk_lat[k]) chk("latency", 32'(cyc - x.cyc), 32'd2);
        inc = (x.w != 0);
      end
    end
    if (clr[k]) mhit[k] = 0;
    else if (inc && mhit[k] < hmax(k)) mhit[k]++;
  endtask

  always @(negedge clk) begin
    if (rst_n) for (int k = 0; k < 2; k++) mon(k);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c0, nacc;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 0; out_ready[k] = 1; clr[k] = 0; mode[k] = 0;
      a[k] = 0; b[k] = 0; c[k] = 0; d[k] = 0; e[k] = 0; f[k] = 0;
      mhit[k] = 0; chk_lat[k] = 1; rnd_rdy[k] = 0; prev_stall[k] = 0;
      prev_w[k] = 0; prev_ones[k] = 0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_w", 32'(w0), 32'd0);
    chk("rst_ones", 32'(ones0), 32'd0);
    chk("rst_hit", 32'(hit0), 32'd0);
    chk("rst_in_ready", 32'(ir0), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(1);

    // Directed mode sweep on identical operands.
    for (int m = 0; m < 4; m++) send_req(0, 8'hFF, 8'h0F, 8'hF0, 8'hFF, 8'h00, 8'h00, 2'(m));
    drain(0);
    chk("t1_hits", 32'(hit0), 32'd2);

    // Back-to-back acceptance at one per cycle.
    c0 = cyc;
    for (int i = 0; i < 3; i++) send_req(0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hAA, 8'h55, 2'd0);
    chk("b2b_cycles", 32'(cyc - c0), 32'd3);
    drain(0);

    // Stall: only two entries fit.
    chk_lat[0] = 0; out_ready[0] = 0; nacc = 0;
    send(0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 2'd0, 2, ok); nacc += int'(ok);
    send(0, 8'hF0, 8'hFF, 8'h0F, 8'hFF, 8'h3C, 8'hC3, 2'd2, 2, ok); nacc += int'(ok);
    send(0, 8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h11, 8'h22, 2'd3, 2, ok); nacc += int'(ok);
    chk("stall_accepted", 32'(nacc), 32'd2);
    chk("stall_in_ready", 32'(ir0), 32'd0);
    out_ready[0] = 1;
    send_req(0, 8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h11, 8'h22, 2'd3);
    drain(0);

    // Random traffic with random backpressure and occasional clears.
    rnd_rdy[0] = 1;
    for (int i = 0; i < 200; i++) begin
      send_req(0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom), 8'($urandom), 2'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        in_valid[0] = 0;
        clr[0] = ($urandom_range(0, 1) == 1);
        step(1);
        clr[0] = 0;
      end
    end
    rnd_rdy[0] = 0; out_ready[0] = 1;
    drain(0);

    // All 64 single-bit input combinations, OR mode.
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = 6'(i);
      send_req(1, {7'b0, v[5]}, {7'b0, v[4]}, {7'b0, v[3]}, {7'b0, v[2]},
               {7'b0, v[1]}, {7'b0, v[0]}, 2'd0);
    end
    drain(1);

    // Saturation of a 4-bit counter, then clear priority.
    clr[1] = 1; step(1); clr[1] = 0;
    for (int i = 0; i < 20; i++) send_req(1, 8'h1, 8'h1, 8'h0, 8'h0, 8'h0, 8'h0, 2'd0);
    drain(1);
    chk("sat_hit", 32'(hit1), 32'd15);
    step(2);
    chk("sat_hold", 32'(hit1), 32'd15);
    clr[1] = 1; step(1); clr[1] = 0;
    for (int i = 0; i < 3; i++) send_req(1, 8'h0, 8'h0, 8'h0, 8'h1, 8'h0, 8'h0, 2'd0);
    drain(1);
    chk("hit_three", 32'(hit1), 32'd3);
    send_req(1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h1, 8'h0, 2'd0);
    in_valid[1] = 0;
    step(1);
    clr[1] = 1; step(1); clr[1] = 0;
    chk("clr_wins", 32'(hit1), 32'd0);
    drain(1);

    // Asynchronous reset with both stages of the 8-bit instance full.
    out_ready[0] = 0;
    send_req(0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    send_req(0, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    in_valid[0] = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(ov0), 32'd0);
    chk("arst_hit", 32'(hit0), 32'd0);
    chk("arst_w", 32'(w0), 32'd0);
    chk("arst_ones", 32'(ones0), 32'd0);
    chk("arst_hit_b", 32'(hit1), 32'd0);
    q0.delete(); q1.delete();
    for (int k = 0; k < 2; k++) begin mhit[k] = 0; prev_stall[k] = 0; end
    @(negedge clk); #2 rst_n = 1'b1;
    step(1);
    chk("post_rst_in_ready", 32'(ir0), 32'd1);
    out_ready[0] = 1; chk_lat[0] = 1;
    send_req(0, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0);
    drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sop_eval_pipe.md
Name: sop_eval_pipe

Overview:
- Parametrised, pipelined successor to the team's single-bit sum-of-products logic block.
- Evaluates three terms bitwise over WIDTH-bit vectors:
  - t0 = a & b
  - t1 = ~c & d
  - t2 = e ^ f
- Combines the terms according to a per-transaction mode.
- Has a 2-stage valid/ready pipeline, a per-result popcount and a saturating count of non-zero results. Sits between a stimulus source and a result consumer in logic-evaluation datapaths.

Parameters:
- WIDTH, 8: bit width of every operand vector and of w.
- CNT_W, 16: width of hit_count.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input transaction offered.
- in_ready  output  1  block can accept the input this cycle.
- a, b, c, d, e, f  input  WIDTH each  operand vectors.
- mode  input  2  combine mode, sampled with the operands.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- w  output  WIDTH  combined result.
- w_ones  output  $clog2(WIDTH+1)  number of 1 bits in w.
- clr_count  input  1  synchronous clear of hit_count.
- hit_count  output  CNT_W  count of accepted results with w != 0; saturates.

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids, out_valid, w, w_ones and hit_count go to 0 immediately. in_ready is 1 after reset. Any in-flight data is discarded.
- Input transfer: in_valid & in_ready on a rising edge.
- Output transfer: out_valid & out_ready on a rising edge.
- Stage 1: on an input transfer, registers t0, t1, t2 and mode; s1_valid is set.
- Stage 2: on advance, registers w and w_ones. out_valid is the stage-2 valid.
- Stage 2 combine, by mode:
  - 00 OR: w = t0 | t1 | t2.
  - 01 AND: w = t0 & t1 & t2.
  - 10 XOR: w = t0 ^ t1 ^ t2.
  - 11 MAJ: w = (t0&t1) | (t0&t2) | (t1&t2).
- Latency: 2 cycles from input transfer to out_valid when out_ready is held high. Throughput is 1 transaction per cycle.
- Advance conditions:
  - s2 loads when s1_valid & (~out_valid | out_ready).
  - s1 loads when in_valid & in_ready.
  - in_ready = ~s1_valid | s2 loads this cycle. This is combinational from out_ready; no combinational path from in_valid to in_ready.
- Stall: with out_ready low, the pipeline fills (2 entries) and then in_ready = 0. w, w_ones and out_valid hold stable while out_valid & ~out_ready.
- Ordering: results leave in acceptance order; none dropped or duplicated.
- Simultaneous output transfer and s2 load: new data replaces old in the same edge, with no bubble.
- hit_count:
  - Increments by 1 on an output transfer with w != 0.
  - Holds at 2^CNT_W-1 (no wrap).
  - clr_count sets it to 0 on the next edge; clear wins over a simultaneous increment.
  - Unaffected by mode.
- mode = MAJ with WIDTH = 1 and any values is a legal configuration; no illegal modes.

Test Plan:
1. WIDTH=8, out_ready=1, mode=00, a=FF b=0F c=F0 d=FF e=00 f=00 -> 2 cycles later w=0F, w_ones=4, hit_count=1. Same operands with mode=01 -> w=00. Mode=10 -> w=00. Mode=11 -> w=0F; hit_count then 2.
2. a=00 b=00 c=FF d=00 e=AA f=55, mode=00 -> w=FF, w_ones=8. Back-to-back 3 transfers complete on 3 consecutive cycles with no bubble.
3. WIDTH=1, mode=00, all 64 combinations of a..f streamed -> each w equals (a&b)|(~c&d)|(e^f), in order. hit_count equals the number of 1 results.
4. out_ready=0 for 5 cycles while offering 3 transactions -> exactly 2 accepted, in_ready=0 thereafter. After out_ready=1, 3 results emerge in order with w held stable during the stall.
5. CNT_W=4, 20 accepted non-zero results -> hit_count=15 and stays 15. clr_count pulsed together with a non-zero transfer -> hit_count=0.
6. rst_n driven low mid-cycle with both stages full -> out_valid=0, hit_count=0 immediately, without waiting for a clock edge. After release, in_ready=1 and the first new result appears 2 cycles after its input transfer.
